// File: rtl/hilo_muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: R-type funct codes,
// FSM state encoding and the iteration count.
package constants;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_FIX} md_state_t;
endpackage

// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface hilo_muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [5:0]      funct;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, funct, rs_val, rt_val, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, funct, rs_val, rt_val, flush,
                  output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_step.sv
// One iteration of the unsigned multiply (shift-add) or restoring divide.
// Mul: i_acc = {partial product, remaining multiplier bits}. Div: i_acc = {remainder, dividend/quotient}.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              i_mode,   // 0 = multiply, 1 = divide
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc
);
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opb} : '0);
    w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    w_ge     = (w_rem_sh >= {1'b0, i_opb});
    // When w_ge holds the true difference is below 2^XLEN, so truncation is exact.
    w_diff   = w_rem_sh[XLEN-1:0] - i_opb;
    if (!i_mode)
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    else
      o_acc = {(w_ge ? w_diff : w_rem_sh[XLEN-1:0]), i_acc[XLEN-2:0], w_ge};
  end
endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also services MTHI/MTLO.
// Operands are reduced to magnitudes on issue and signs are applied in FIX.
module hilo_muldiv
  import constants::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = MD_ITERS
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_muldiv_if.slave  bus
);
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  md_state_t         r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_step;
  logic [XLEN-1:0]   r_opb, r_rs, r_hi, r_lo;
  logic              r_is_div, r_neg_q, r_neg_r, r_div0, r_done;

  logic                   w_accept, w_is_mul, w_is_div, w_signed, w_sa, w_sb;
  logic signed [XLEN-1:0] w_rs_s, w_rt_s;
  logic [XLEN-1:0]        w_mag_a, w_mag_b;

  function automatic logic [2*XLEN-1:0] neg_wide(input logic n, input logic [2*XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_word(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  assign w_accept = (r_state == MD_IDLE) && bus.start && !bus.flush;
  assign w_is_mul = (bus.funct == FN_MULT) || (bus.funct == FN_MULTU);
  assign w_is_div = (bus.funct == FN_DIV)  || (bus.funct == FN_DIVU);
  assign w_signed = (bus.funct == FN_MULT) || (bus.funct == FN_DIV);
  assign w_rs_s   = bus.rs_val;
  assign w_rt_s   = bus.rt_val;
  assign w_sa     = w_signed && w_rs_s[XLEN-1];
  assign w_sb     = w_signed && w_rt_s[XLEN-1];
  // -(0x8000_0000) wraps to itself, which is the correct unsigned magnitude.
  assign w_mag_a  = w_sa ? -bus.rs_val : bus.rs_val;
  assign w_mag_b  = w_sb ? -bus.rt_val : bus.rt_val;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_mode (r_is_div),
    .i_acc  (r_acc),
    .i_opb  (r_opb),
    .o_acc  (w_step)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (w_accept && w_is_mul)      w_next = MD_MUL;
               else if (w_accept && w_is_div) w_next = MD_DIV;
      MD_MUL:  if (r_cnt == LAST) w_next = MD_FIX;
      MD_DIV:  if (r_cnt == LAST) w_next = MD_FIX;
      MD_FIX:  w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
    if (bus.flush) w_next = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= (r_state == MD_FIX) && !bus.flush;
      if (w_accept) r_cnt <= '0;
      else if (r_state == MD_MUL || r_state == MD_DIV) r_cnt <= r_cnt + 1'b1;
      if (w_accept && bus.funct == FN_MTHI) r_hi <= bus.rs_val;
      if (w_accept && bus.funct == FN_MTLO) r_lo <= bus.rs_val;
      if (r_state == MD_FIX && !bus.flush) begin
        if (!r_is_div) begin
          {r_hi, r_lo} <= neg_wide(r_neg_q, r_acc);
        end else if (r_div0) begin
          r_lo <= '1;
          r_hi <= r_rs;
        end else begin
          r_lo <= neg_word(r_neg_q, r_acc[XLEN-1:0]);
          r_hi <= neg_word(r_neg_r, r_acc[2*XLEN-1:XLEN]);
        end
      end
    end
  end

  // Operand/sign latches are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (w_accept && (w_is_mul || w_is_div)) begin
      r_is_div <= w_is_div;
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_div0   <= (bus.rt_val == '0);
      r_rs     <= bus.rs_val;
      r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      r_opb    <= w_is_div ? w_mag_b : w_mag_a;
    end else if (r_state == MD_MUL || r_state == MD_DIV) begin
      r_acc <= w_step;
    end
  end

  assign bus.busy = (r_state != MD_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus randomized
// operations compared against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv;
  import constants::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.XLEN(32)) bus();

  hilo_muldiv #(.XLEN(32), .ITERS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    eh = m_hi; el = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      FN_MULT:  begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
      FN_MULTU: begin up = 64'(a) * 64'(b); eh = up[63:32]; el = up[31:0]; end
      FN_DIV:   if (b == 0) begin el = '1; eh = a; end
                else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      FN_DIVU:  if (b == 0) begin el = '1; eh = a; end
                else begin el = a / b; eh = a % b; end
      FN_MTHI:  eh = a;
      FN_MTLO:  el = a;
      default:  ;
    endcase
  endfunction

  // Issue one mul/div at the current negedge and follow it to completion.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    int cyc, gaps;
    logic [31:0] eh, el;
    model(f, a, b, eh, el);
    bus.start = 1'b1; bus.funct = f; bus.rs_val = a; bus.rt_val = b;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.rs_val = $urandom; bus.rt_val = $urandom;
    cyc = 0; gaps = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy !== 1'b1) gaps++;
      @(posedge clk); @(negedge clk); cyc++;
    end
    n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL %s latency: got %0d cycles, expected 33", tag, cyc); end
    n_checks++; if (gaps !== 0) begin n_errors++; $display("FAIL %s busy_gap: got %0d low cycles, expected 0", tag, gaps); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL %s busy_at_done: got %b, expected 0", tag, bus.busy); end
    n_checks++; if (bus.hi !== eh) begin n_errors++; $display("FAIL %s hi: got %h, expected %h", tag, bus.hi, eh); end
    n_checks++; if (bus.lo !== el) begin n_errors++; $display("FAIL %s lo: got %h, expected %h", tag, bus.lo, el); end
    m_hi = eh; m_lo = el;
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] v, input string tag);
    logic [31:0] eh, el;
    model(f, v, 32'h0, eh, el);
    bus.start = 1'b1; bus.funct = f; bus.rs_val = v;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL %s busy: got %b, expected 0", tag, bus.busy); end
    n_checks++; if (bus.hi !== eh) begin n_errors++; $display("FAIL %s hi: got %h, expected %h", tag, bus.hi, eh); end
    n_checks++; if (bus.lo !== el) begin n_errors++; $display("FAIL %s lo: got %h, expected %h", tag, bus.lo, el); end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_errors++; $display("FAIL reset_ctl: got busy/done %b, expected 00", {bus.busy, bus.done}); end
    n_checks++; if ({bus.hi, bus.lo} !== 64'h0) begin n_errors++; $display("FAIL reset_hilo: got %h, expected 0", {bus.hi, bus.lo}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mthi_mtlo();
    move_to(FN_MTHI, 32'h1234_5678, "mthi");
    move_to(FN_MTLO, 32'h9ABC_DEF0, "mtlo");
  endtask

  task automatic test_mult();
    run_op(FN_MULT, 32'hFFFF_FFFE, 32'h0000_0003, "mult");
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL done_pulse: got %b, expected 0", bus.done); end
    run_op(FN_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
  endtask

  task automatic test_div();
    run_op(FN_DIV,  32'hFFFF_FFF9, 32'h2, "div_neg7_2");
    run_op(FN_DIVU, 32'h7, 32'h2, "divu_7_2");
    run_op(FN_DIV,  32'h55, 32'h0, "div_by0");
    run_op(FN_DIVU, 32'h55, 32'h0, "divu_by0");
    run_op(FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
  endtask

  task automatic test_random();
    logic [5:0] fns [6] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO};
    logic [5:0] f;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      f = fns[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'h0;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      if (f == FN_MTHI || f == FN_MTLO) move_to(f, a, "rand_mt");
      else run_op(f, a, b, "rand_op");
    end
  endtask

  task automatic test_back_to_back();
    run_op(FN_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, "b2b_first");
    run_op(FN_DIV, 32'h8765_4321, 32'h0000_1234, "b2b_second");
  endtask

  task automatic test_flush();
    int seen;
    bus.start = 1'b1; bus.funct = FN_MULT; bus.rs_val = 32'h0001_2345; bus.rt_val = 32'h0006_789A;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    bus.flush = 1'b1; bus.start = 1'b1; bus.funct = FN_MULT;
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL flush_busy: got %b, expected 0", bus.busy); end
    n_checks++; if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin n_errors++; $display("FAIL flush_hilo: got %h, expected %h", {bus.hi, bus.lo}, {m_hi, m_lo}); end
    seen = 0;
    repeat (40) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
      @(posedge clk); @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL flush_quiet: got %0d active cycles, expected 0", seen); end
    bus.flush = 1'b1; bus.start = 1'b1; bus.funct = FN_DIVU;
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL flush_idle_start: got busy %b, expected 0", bus.busy); end
  endtask

  task automatic test_async_reset();
    move_to(FN_MTHI, 32'hA5A5_0001, "pre_rst_hi");
    move_to(FN_MTLO, 32'h5A5A_0002, "pre_rst_lo");
    bus.start = 1'b1; bus.funct = FN_DIV; bus.rs_val = 32'h0123_4567; bus.rt_val = 32'h89;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (19) begin @(posedge clk); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_errors++; $display("FAIL async_rst_ctl: got %b, expected 00", {bus.busy, bus.done}); end
    n_checks++; if ({bus.hi, bus.lo} !== 64'h0) begin n_errors++; $display("FAIL async_rst_hilo: got %h, expected 0", {bus.hi, bus.lo}); end
    @(negedge clk); rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op(FN_MULTU, 32'd5, 32'd6, "multu_after_rst");
  endtask

  initial begin
    bus.start = 1'b0; bus.funct = '0; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit that owns the MIPS HI/LO register pair. It executes R-type MULT, MULTU, DIV, DIVU, MTHI and MTLO issued by the execute stage, and exposes HI/LO to the writeback path for MFHI/MFLO. It sits beside the ALU in execute. The pipeline stalls any MFHI/MFLO while `busy` is high.

## Interface
Parameters:
- `XLEN`, 32: operand width; only 32 is supported.
- `ITERS`, 32: iteration count per multiply or divide. It must equal `XLEN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  issue request, qualified by `funct`.
- `funct`  in  6  R-type funct field, using the `FN_*` values from package `constants`.
- `rs_val`  in  32  operand A: multiplicand, dividend, or MTHI/MTLO source.
- `rt_val`  in  32  operand B: multiplier or divisor.
- `flush`  in  1  abort any in-flight operation.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse when HI/LO are written by a multiply or divide.
- `hi`  out  32  current HI register.
- `lo`  out  32  current LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset values: state IDLE; `hi`, `lo`, `done` and `busy` all 0.
- In IDLE, `start` is accepted on a rising edge, with this behaviour per `funct`:
  - `FN_MTHI`: HI <= `rs_val`; state stays IDLE; no `done`.
  - `FN_MTLO`: LO <= `rs_val`; state stays IDLE; no `done`.
  - `FN_MULT`/`FN_MULTU`: latch operand magnitudes (absolute values for the signed op) and the result sign; go to MUL.
  - `FN_DIV`/`FN_DVIU`: same latching; go to DIV.
  - Any other `funct`: ignored.
- `start` while `busy` is ignored. Operands are not re-sampled after acceptance.
- MUL: unsigned shift-add on a 64-bit accumulator, one multiplier bit per cycle, `ITERS` cycles, then go to FIX.
- DIV: restoring division, one quotient bit per cycle, `ITERS` cycles, then go to FIX.
- FIX: apply signs, write HI/LO, pulse `done`, return to IDLE.
  - Signed MULT: negate the 64-bit product if the operand signs differ; {HI,LO} <= product.
  - Signed DIV: quotient sign is signA xor signB; remainder takes the dividend's sign.
  - DIV/DIVU: LO <= quotient, HI <= remainder.
- |−2^31| is held as unsigned 0x8000_0000, which fits the magnitude path.
- Divisor = 0 (DIV and DIVU): LO <= 0xFFFF_FFFF, HI <= dividend (raw `rs_val`). The iteration still runs so latency is unchanged.
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO <= 0x8000_0000, HI <= 0. This is wraparound, not a trap.
- `flush`: state goes to IDLE on the next edge. HI/LO keep their pre-operation values and `done` is not pulsed. `flush` takes priority over `start` in the same cycle and over FIX (the FIX write is suppressed).
- Asynchronous reset mid-operation: everything returns to reset values immediately.

## Timing
- Let E0 be the edge that accepts a MULT, MULTU, DIV or DIVU.
- `busy` is high after E0 through E33: 32 iteration edges E1..E32, then the FIX edge E33.
- After E33, `hi`/`lo` hold the new values, `done` is high for exactly one cycle, and `busy` is low.
- A new `start` in the cycle `done` is high is accepted at E34.
- Throughput: one multiply/divide per 34 cycles.
- MTHI/MTLO: `hi`/`lo` update at the accepting edge and are visible the next cycle; `busy` stays low.
- `hi`/`lo` are direct register outputs with no combinational path from inputs.

## Structure
- Add to package `constants`:
  - `typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_FIX} md_state_t`.
  - Localparam `MD_ITERS = 32`.
- Sub-module `muldiv_step`: combinational single-iteration datapath (one shift-add or one restore-subtract step), selected by a mode bit.
  - The parent holds the FSM, counter, operand/sign latches and HI/LO.

## Test plan
- MTHI 0x1234_5678 then MTLO 0x9ABC_DEF0 -> `hi`/`lo` equal those values one cycle after each accept; `busy` never rises.
- MULT 0xFFFF_FFFE × 0x0000_0003 -> after 33 edges HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; `done` pulses once; MULTU with the same operands -> HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV −7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 7 / 2 -> LO=3, HI=1.
- DIV/DIVU with divisor 0 and dividend 0x55 -> LO=0xFFFF_FFFF, HI=0x55 at the normal latency; DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- Start MULT; assert `flush` on cycle 10 and also hold `start`=1 with a second MULT -> `busy` low next cycle, HI/LO unchanged, no `done`, second MULT not accepted.
- Assert `rst_n` low mid-DIV (cycle 20) -> `busy`, `done`, `hi`, `lo` go to 0 asynchronously; a MULTU 5 × 6 issued after release -> LO=30, HI=0.
